// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-side bundle between the PC generator (master) and HDU/EX/trap/debug/imem (slave)
// Signals: stall_i, req_ready_i, branch_i/branch_addr_i, trap_i/trap_addr_i, halt_i, resume_i  -> into pc_gen
//          pc_o, ce_o, halted_o, misalign_o, fetch_cnt_o                                         <- from pc_gen
interface pc_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 32
);
  logic                  stall_i;
  logic                  req_ready_i;
  logic                  branch_i;
  logic [ADDR_WIDTH-1:0] branch_addr_i;
  logic                  trap_i;
  logic [ADDR_WIDTH-1:0] trap_addr_i;
  logic                  halt_i;
  logic                  resume_i;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  ce_o;
  logic                  halted_o;
  logic                  misalign_o;
  logic [CNT_WIDTH-1:0]  fetch_cnt_o;
  modport master (
    input  stall_i, req_ready_i, branch_i, branch_addr_i, trap_i, trap_addr_i, halt_i, resume_i,
    output pc_o, ce_o, halted_o, misalign_o, fetch_cnt_o
  );
  modport slave (
    output stall_i, req_ready_i, branch_i, branch_addr_i, trap_i, trap_addr_i, halt_i, resume_i,
    input  pc_o, ce_o, halted_o, misalign_o, fetch_cnt_o
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: IF-stage program counter with reset vector, trap/branch redirects, backpressure, debug halt and fetch counter
// Ports: clk_i (rising edge), rst_ni (sync, active-low), bus (pc_gen_if.master: requests in, pc_o/ce_o/halted_o/misalign_o/fetch_cnt_o out)
module pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    STEP         = 4,
  parameter int                    CNT_WIDTH    = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  pc_gen_if.master   bus
);
  typedef enum logic [1:0] {S_RESET, S_RUN, S_HALT} state_t;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STEP - 1);
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_ce;
  logic                  r_halted;
  logic                  r_misalign;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic                  w_accept;
  logic                  w_redir;
  logic [ADDR_WIDTH-1:0] w_target;
  // trap outranks branch, so the target mux only needs trap_i as select
  assign w_target = bus.trap_i ? bus.trap_addr_i : bus.branch_addr_i;
  assign w_redir  = bus.trap_i | bus.branch_i;
  assign w_accept = r_ce & bus.req_ready_i & ~bus.stall_i;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_RESET;
      r_pc       <= RESET_VECTOR;
      r_ce       <= 1'b0;
      r_halted   <= 1'b0;
      r_misalign <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_misalign <= 1'b0;
      if (r_state == S_RESET) begin
        r_state <= S_RUN;
        r_ce    <= 1'b1;
      end else begin
        // a redirect squashes any fetch accepted in the same cycle, so it is not counted
        if (w_redir) begin
          r_pc       <= w_target & ALIGN_MASK;
          r_misalign <= |(w_target & ~ALIGN_MASK);
        end else if (w_accept) begin
          r_pc  <= r_pc + ADDR_WIDTH'(STEP);
          r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
        if (r_state == S_RUN && bus.halt_i) begin
          r_state  <= S_HALT;
          r_ce     <= 1'b0;
          r_halted <= 1'b1;
        end else if (r_state == S_HALT && bus.resume_i && !bus.halt_i) begin
          r_state  <= S_RUN;
          r_ce     <= 1'b1;
          r_halted <= 1'b0;
        end
      end
    end
  end
  assign bus.pc_o        = r_pc;
  assign bus.ce_o        = r_ce;
  assign bus.halted_o    = r_halted;
  assign bus.misalign_o  = r_misalign;
  assign bus.fetch_cnt_o = r_cnt;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: table-driven directed check of pc_gen (RESET_VECTOR=0x8000_0000, STEP=4, CNT_WIDTH=4)
module tb_pc_gen;
  typedef struct {
    logic        rn, st, rd, b;
    logic [31:0] ba;
    logic        t;
    logic [31:0] ta;
    logic        h, r;
    logic [31:0] epc;
    logic        ece, eh, em;
    logic [3:0]  ec;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  vec_t q[$];
  always #5 clk = ~clk;
  pc_gen_if #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) bus ();
  pc_gen #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h8000_0000), .STEP(4), .CNT_WIDTH(4)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bus(bus)
  );
  task automatic add(input logic rn, st, rd, b, input logic [31:0] ba, input logic t, input logic [31:0] ta,
                     input logic h, r, input logic [31:0] epc, input logic ece, eh, em, input logic [3:0] ec);
    vec_t x;
    x.rn = rn; x.st = st; x.rd = rd; x.b = b; x.ba = ba; x.t = t; x.ta = ta; x.h = h; x.r = r;
    x.epc = epc; x.ece = ece; x.eh = eh; x.em = em; x.ec = ec;
    q.push_back(x);
  endtask
  task automatic drive(input vec_t x);
    rst_n = x.rn;
    bus.stall_i = x.st;
    bus.req_ready_i = x.rd;
    bus.branch_i = x.b;
    bus.branch_addr_i = x.ba;
    bus.trap_i = x.t;
    bus.trap_addr_i = x.ta;
    bus.halt_i = x.h;
    bus.resume_i = x.r;
  endtask
  task automatic idle(input logic st, rd, h, r);
    rst_n = 1'b1; bus.stall_i = st; bus.req_ready_i = rd; bus.branch_i = 1'b0; bus.branch_addr_i = '0;
    bus.trap_i = 1'b0; bus.trap_addr_i = '0; bus.halt_i = h; bus.resume_i = r;
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [31:0] epc, input logic ece, eh, em, input logic [3:0] ec);
    chk({tag, " pc"}, bus.pc_o, epc);
    chk({tag, " ce"}, 32'(bus.ce_o), 32'(ece));
    chk({tag, " halted"}, 32'(bus.halted_o), 32'(eh));
    chk({tag, " misalign"}, 32'(bus.misalign_o), 32'(em));
    chk({tag, " cnt"}, 32'(bus.fetch_cnt_o), 32'(ec));
  endtask
  initial begin
    //   rn st rd b  ba            t  ta            h  r  pc            ce h  m  cnt
    add(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8000_0000, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8000_0000, 0, 0, 0, 0);
    add(0, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8000_0000, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8000_0000, 1, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8000_0004, 1, 0, 0, 1);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8000_0008, 1, 0, 0, 2);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8000_000C, 1, 0, 0, 3);
    add(1, 0, 1, 1, 32'h10,       0, 32'h0,        0, 0, 32'h10,        1, 0, 0, 3);
    add(1, 1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h10,        1, 0, 0, 3);
    add(1, 1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h10,        1, 0, 0, 3);
    add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h10,        1, 0, 0, 3);
    add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h10,        1, 0, 0, 3);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h14,        1, 0, 0, 4);
    add(1, 1, 1, 1, 32'h100,      1, 32'h200,      0, 0, 32'h200,       1, 0, 0, 4);
    add(1, 0, 1, 1, 32'h102,      0, 32'h0,        0, 0, 32'h100,       1, 0, 1, 4);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h104,       1, 0, 0, 5);
    add(1, 0, 1, 0, 32'h0,        1, 32'h203,      0, 0, 32'h200,       1, 0, 1, 5);
    add(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h200,       1, 0, 0, 5);
    add(1, 0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0,       0, 0, 32'hFFFF_FFFC, 1, 0, 0, 5);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,         1, 0, 0, 6);
    add(1, 0, 1, 1, 32'h40,       0, 32'h0,        0, 0, 32'h40,        1, 0, 0, 6);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h44,        0, 1, 0, 7);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h44,        0, 1, 0, 7);
    add(1, 0, 1, 1, 32'h80,       0, 32'h0,        0, 0, 32'h80,        0, 1, 0, 7);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h80,        0, 1, 0, 7);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h80,        1, 0, 0, 7);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h84,        1, 0, 0, 8);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h88,        0, 1, 0, 9);
    add(0, 0, 1, 1, 32'h300,      0, 32'h0,        0, 0, 32'h8000_0000, 0, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8000_0000, 1, 0, 0, 0);
    foreach (q[i]) begin
      drive(q[i]);
      cyc();
      chk_all($sformatf("v%0d", i), q[i].epc, q[i].ece, q[i].eh, q[i].em, q[i].ec);
    end
    // counter wrap: 16 accepts from zero return the 4-bit count to 0
    idle(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (15) cyc();
    chk_all("wrap15", 32'h8000_003C, 1'b1, 1'b0, 1'b0, 4'd15);
    cyc();
    chk_all("wrap16", 32'h8000_0040, 1'b1, 1'b0, 1'b0, 4'd0);
    // halt and resume together while running: halt wins, the sampled fetch still counts
    idle(1'b0, 1'b1, 1'b1, 1'b1);
    cyc();
    chk_all("halt_res_run", 32'h8000_0044, 1'b0, 1'b1, 1'b0, 4'd1);
    idle(1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_all("halt_hold", 32'h8000_0044, 1'b0, 1'b1, 1'b0, 4'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
